// File: rtl/alu.sv
// rtl/alu.sv - registered 32-bit ALU with single-cycle simple ops and a 32-cycle iterative MUL/DIV/MOD engine
module alu (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [7:0]  operator,
    input  logic        op_valid,
    output logic        operation_done,
    output logic [31:0] result
);

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_SHL = 8'h06;
    localparam logic [7:0] OP_SHR = 8'h07;
    localparam logic [7:0] OP_SRA = 8'h08;
    localparam logic [7:0] OP_MUL = 8'h09;
    localparam logic [7:0] OP_DIV = 8'h0A;
    localparam logic [7:0] OP_MOD = 8'h0B;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        is_iter;
    logic [31:0] simple_res;
    logic [31:0] mul_acc;
    logic [32:0] div_tmp;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [31:0] div_quo;

    assign operation_done = done_q;
    assign result         = result_q;
    assign is_iter        = (operator == OP_MUL) || (operator == OP_DIV) || (operator == OP_MOD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_valid && is_iter) state_d = BUSY;
            BUSY:    if (cnt_q == 5'd0)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        simple_res = 32'h0;
        case (operator)
            OP_ADD:  simple_res = operand_a + operand_b;
            OP_SUB:  simple_res = operand_a - operand_b;
            OP_AND:  simple_res = operand_a & operand_b;
            OP_OR:   simple_res = operand_a | operand_b;
            OP_XOR:  simple_res = operand_a ^ operand_b;
            OP_SHL:  simple_res = operand_a << operand_b[4:0];
            OP_SHR:  simple_res = operand_a >> operand_b[4:0];
            OP_SRA:  simple_res = $signed(operand_a) >>> operand_b[4:0];
            default: simple_res = 32'h0;
        endcase
    end

    // One engine step: a_q is the shifting multiplicand (MUL) or the dividend/quotient shift register (DIV/MOD).
    // A zero divisor needs no special case: every step subtracts, giving all-ones quotient and remainder = a.
    always_comb begin
        mul_acc = acc_q + (b_q[0] ? a_q : 32'h0);
        div_tmp = {acc_q, a_q[31]};
        div_ge  = div_tmp >= {1'b0, b_q};
        div_rem = div_ge ? (div_tmp[31:0] - b_q) : div_tmp[31:0];
        div_quo = {a_q[30:0], div_ge};
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d = operator;
                    a_d  = operand_a;
                    b_d  = operand_b;
                    if (is_iter) begin
                        acc_d = 32'h0;
                        cnt_d = 5'd31;
                    end else begin
                        result_d = simple_res;
                        done_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = div_rem;
                    a_d   = div_quo;
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    cnt_d  = 5'd0;
                    done_d = 1'b1;
                    if (op_q == OP_MUL)      result_d = mul_acc;
                    else if (op_q == OP_DIV) result_d = div_quo;
                    else                     result_d = div_rem;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= 5'd0;
            op_q     <= 8'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            acc_q    <= 32'h0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;

    logic        clock;
    logic        reset;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [7:0]  operator;
    logic        op_valid;
    logic        operation_done;
    logic [31:0] result;

    int tests;
    int fails;

    alu dut (
        .clock          (clock),
        .reset          (reset),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .operator       (operator),
        .op_valid       (op_valid),
        .operation_done (operation_done),
        .result         (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one request at the negedge; returns #1 after the accept edge with op_valid dropped.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        operator  = op;
        operand_a = a;
        operand_b = b;
        op_valid  = 1'b1;
        @(posedge clock);
        #1;
        op_valid  = 1'b0;
    endtask

    // Counts edges after the accept edge until done; lat = 0 if it never came within 40 edges.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (operation_done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        op_valid = 1'b0;
        operator = 8'h0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (result !== 32'h0 || operation_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: result=%h done=%b, required 00000000/0", result, operation_done);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_arith;
        issue(8'h01, 32'hFFFFFFFF, 32'h00000001);
        tests++;
        if (operation_done !== 1'b1 || result !== 32'h00000000) begin
            fails++;
            $display("FAIL add_wrap: done=%b result=%h, required 1/00000000", operation_done, result);
        end
        @(posedge clock);
        #1;
        tests++;
        if (operation_done !== 1'b0 || result !== 32'h00000000) begin
            fails++;
            $display("FAIL add_pulse_hold: done=%b result=%h, required 0/00000000", operation_done, result);
        end
        issue(8'h02, 32'h0, 32'h1);
        tests++;
        if (operation_done !== 1'b1 || result !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL sub_wrap: done=%b result=%h, required 1/ffffffff", operation_done, result);
        end
    endtask

    task automatic test_logic;
        logic [7:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [31:0] exp [6];
        ops = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h07};
        as  = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1, 32'h80000000, 32'h80000000};
        bs  = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'd33, 32'd4, 32'd4};
        exp = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h2, 32'hF8000000, 32'h08000000};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            tests++;
            if (operation_done !== 1'b1 || result !== exp[i]) begin
                fails++;
                $display("FAIL logic_op_%h: done=%b result=%h, required 1/%h", ops[i], operation_done, result, exp[i]);
            end
        end
    endtask

    task automatic test_iter;
        logic [7:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [31:0] exp [6];
        int lat;
        ops = '{8'h09, 8'h09, 8'h0A, 8'h0B, 8'h0A, 8'h0B};
        as  = '{32'd123, 32'h10000, 32'd100, 32'd100, 32'd5, 32'd5};
        bs  = '{32'd456, 32'h10000, 32'd7, 32'd7, 32'd0, 32'd0};
        exp = '{32'h0000DB18, 32'h0, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            operand_a = 32'hDEADBEEF;
            operand_b = 32'h12345678;
            operator  = 8'h01;
            tests++;
            if (operation_done !== 1'b0) begin
                fails++;
                $display("FAIL iter_%0d_early_done: done=%b, required 0", i, operation_done);
            end
            wait_done(lat);
            tests++;
            if (lat != 32 || result !== exp[i]) begin
                fails++;
                $display("FAIL iter_%0d_op_%h: latency=%0d result=%h, required 32/%h", i, ops[i], lat, result, exp[i]);
            end
        end
    endtask

    task automatic test_busy;
        int lat;
        issue(8'h09, 32'd3, 32'd5);
        repeat (3) @(posedge clock);
        issue(8'h01, 32'd1000, 32'd1);
        tests++;
        if (operation_done !== 1'b0) begin
            fails++;
            $display("FAIL busy_add_dropped: done=%b, required 0", operation_done);
        end
        wait_done(lat);
        tests++;
        if (lat != 28 || result !== 32'd15) begin
            fails++;
            $display("FAIL busy_mul_result: latency_after_add=%0d result=%h, required 28/0000000f", lat, result);
        end
        @(posedge clock);
        #1;
        tests++;
        if (operation_done !== 1'b0 || result !== 32'd15) begin
            fails++;
            $display("FAIL busy_no_extra_done: done=%b result=%h, required 0/0000000f", operation_done, result);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            operator  = 8'h01;
            operand_a = 32'd10 * i + 32'd1;
            operand_b = 32'd100 + i;
            op_valid  = 1'b1;
            @(posedge clock);
            #1;
            tests++;
            if (operation_done !== 1'b1 || result !== (32'd11 * i + 32'd101)) begin
                fails++;
                $display("FAIL b2b_%0d: done=%b result=%h, required 1/%h", i, operation_done, result, 32'd11 * i + 32'd101);
            end
        end
        op_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen;
        issue(8'h0A, 32'd1000, 32'd3);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (result !== 32'h0 || operation_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_div: result=%h done=%b, required 00000000/0", result, operation_done);
        end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clock);
            #1;
            if (operation_done === 1'b1) seen++;
        end
        tests++;
        if (seen != 0 || result !== 32'h0) begin
            fails++;
            $display("FAIL reset_abort_no_done: done_pulses=%0d result=%h, required 0/00000000", seen, result);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        operator  = 8'h01;
        operand_a = 32'd2;
        operand_b = 32'd3;
        op_valid  = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        tests++;
        if (operation_done !== 1'b1 || result !== 32'd5) begin
            fails++;
            $display("FAIL reset_release_accept: done=%b result=%h, required 1/00000005", operation_done, result);
        end
    endtask

    task automatic test_unknown;
        issue(8'h55, 32'h12345678, 32'h9ABCDEF0);
        tests++;
        if (operation_done !== 1'b1 || result !== 32'h0) begin
            fails++;
            $display("FAIL unknown_op: done=%b result=%h, required 1/00000000", operation_done, result);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_arith;
        test_logic;
        test_iter;
        test_busy;
        test_back_to_back;
        test_reset_mid;
        test_unknown;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit arithmetic/logic unit with a single-request handshake. It sits directly under the ALU testbench top and accepts an operator and two operands on `op_valid`. It returns `result` with a one-cycle `operation_done` pulse. Simple operations complete in 1 cycle; multiply, divide and modulo use an iterative 32-cycle engine. Every accepted operation must produce `operation_done` within 32 cycles, because the bench-level watchdog times out on a stalled ALU.

## Interface
- No parameters. Data width is fixed at 32 and operator width at 8.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `operand_a`  in  32  first operand; shift source; dividend.
- `operand_b`  in  32  second operand; shift amount is `[4:0]`; divisor.
- `operator`  in  8  opcode.
- `op_valid`  in  1  request strobe, sampled on rising edge.
- `operation_done`  out  1  one-cycle pulse; `result` is valid while it is high.
- `result`  out  32  registered result, held until the next completion.

## Operation
- Opcodes:
  - 0x01 ADD: a+b mod 2^32.
  - 0x02 SUB: a-b mod 2^32.
  - 0x03 AND.
  - 0x04 OR.
  - 0x05 XOR.
  - 0x06 SHL: a << b[4:0].
  - 0x07 SHR: logical right shift.
  - 0x08 SRA: arithmetic right shift.
  - 0x09 MUL: low 32 bits of unsigned a*b.
  - 0x0A DIV: unsigned quotient.
  - 0x0B MOD: unsigned remainder.
- Any other opcode returns result 0x00000000 with single-cycle completion.
- Divide by zero: DIV returns 0xFFFFFFFF; MOD returns a.
- No carry, overflow or error outputs.
- State machine:
  - IDLE: accepts a request when `op_valid`=1 and latches operands and operator.
  - A simple op (all opcodes except 0x09–0x0B) is computed and registered at the accept edge, and the FSM stays in IDLE.
  - MUL/DIV/MOD: IDLE → BUSY. A 5-bit counter is loaded with 31.
  - MUL uses shift-add; DIV/MOD use restoring shift-subtract, one bit per cycle.
  - BUSY → IDLE on the edge where the counter is 0. At that edge `result` is registered and `operation_done` is set.
  - In BUSY, `op_valid` is ignored. The request is dropped, not queued.
- `result` holds its last value whenever `operation_done`=0.

## Timing
- Reset state: FSM IDLE, `result`=0, `operation_done`=0, counter 0.
- Simple-op latency: request accepted at edge N gives `operation_done`=1 and valid `result` after edge N, for exactly one cycle.
- Back-to-back simple ops may issue every cycle, so `operation_done` may stay high on consecutive cycles.
- Iterative-op latency: request accepted at edge N gives `operation_done`=1 after edge N+32, for one cycle.
- The next request is acceptable at edge N+32, i.e. the same cycle `operation_done` rises.
- Operand or operator changes after the accept edge have no effect on the operation in flight.
- Reset asserted mid-operation aborts it immediately: outputs return to reset values and no `operation_done` is produced.
- Deasserting reset right before an edge with `op_valid`=1 means that request is accepted at that edge.

## Test plan
- Wraparound, single-cycle: ADD 0xFFFFFFFF+0x00000001 → result 0x00000000, done 1 cycle after accept. SUB 0x0−0x1 → 0xFFFFFFFF.
- Logic and shifts:
  - AND/OR/XOR of 0xF0F0F0F0 and 0xFF00FF00 → 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0.
  - SHL 0x1 by b=33 → 0x00000002.
  - SRA 0x80000000 by 4 → 0xF8000000.
- Multiply: MUL 123*456 → 0x0000DB18 exactly 32 cycles after accept. MUL 0x10000*0x10000 → 0x00000000.
- Divide: DIV 100/7 → 14 and MOD 100/7 → 2, each at 32 cycles. DIV 5/0 → 0xFFFFFFFF; MOD 5/0 → 5.
- Busy handling: issue ADD while a MUL is busy → ADD dropped, only the MUL completes. A back-to-back ADD every cycle → done high on each following cycle with the matching sums.
- Reset: assert reset at cycle 10 of a DIV → done never pulses and result=0. Opcode 0x55 → result 0 with done after 1 cycle.
